// File: rtl/writeback_queue_if.sv
// writeback_queue_if: groups the producer handshake, register-file write ports and hazard lookup of the writeback queue.
// Ports (via modports):
//   slave  (queue side): receives in_* and wb_hold/read_addr_*; drives in_ready, write_*, pending_*, count.
//   master (producer, register-file and decode side): the opposite directions.
interface writeback_queue_if #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [ADDR_WIDTH-1:0]       in_addr_1;
    logic [DATA_WIDTH-1:0]       in_data_1;
    logic                        in_byte_only;
    logic                        in_dual;
    logic [ADDR_WIDTH-1:0]       in_addr_2;
    logic [DATA_WIDTH-1:0]       in_data_2;
    logic                        wb_hold;
    logic                        write_enable_1;
    logic [ADDR_WIDTH-1:0]       write_addr_1;
    logic [DATA_WIDTH-1:0]       write_data_1;
    logic                        first_byte_only;
    logic                        write_enable_2;
    logic [ADDR_WIDTH-1:0]       write_addr_2;
    logic [DATA_WIDTH-1:0]       write_data_2;
    logic [ADDR_WIDTH-1:0]       read_addr_1;
    logic [ADDR_WIDTH-1:0]       read_addr_2;
    logic                        pending_1;
    logic                        pending_2;
    logic                        pending_15;
    logic [$clog2(DEPTH):0]      count;

    modport slave (
        input  in_valid, in_addr_1, in_data_1, in_byte_only, in_dual, in_addr_2, in_data_2,
        input  wb_hold, read_addr_1, read_addr_2,
        output in_ready, write_enable_1, write_addr_1, write_data_1, first_byte_only,
        output write_enable_2, write_addr_2, write_data_2, pending_1, pending_2, pending_15, count
    );

    modport master (
        output in_valid, in_addr_1, in_data_1, in_byte_only, in_dual, in_addr_2, in_data_2,
        output wb_hold, read_addr_1, read_addr_2,
        input  in_ready, write_enable_1, write_addr_1, write_data_1, first_byte_only,
        input  write_enable_2, write_addr_2, write_data_2, pending_1, pending_2, pending_15, count
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: FIFO of register writes issued to a dual-port register file, one entry per cycle,
// splitting same-address dual writes into two cycles and reporting pending-write hazards.
// Ports: clk, rst (async, active-high); bus (writeback_queue_if.slave) carrying the push handshake,
//   registered write ports, wb_hold, hazard read addresses/flags and occupancy count.
module writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ISSUE, SPLIT} state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a1;
        logic [DATA_WIDTH-1:0] d1;
        logic                  bo;
        logic                  dual;
        logic [ADDR_WIDTH-1:0] a2;
        logic [DATA_WIDTH-1:0] d2;
    } entry_t;

    state_t                state_q, state_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  we1_q, we1_d, we2_q, we2_d, fbo_q, fbo_d;
    logic [ADDR_WIDTH-1:0] wa1_q, wa1_d, wa2_q, wa2_d;
    logic [DATA_WIDTH-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
    entry_t                head_e;
    logic                  push, pop, can_issue, same_addr, vld;
    logic                  p1, p2, p15;

    function automatic logic hits(input entry_t e, input logic [ADDR_WIDTH-1:0] a);
        return e.a1 == a || (e.dual && e.a2 == a);
    endfunction

    assign bus.in_ready        = count_q < CW'(DEPTH);
    assign bus.count           = count_q;
    assign bus.write_enable_1  = we1_q;
    assign bus.write_addr_1    = wa1_q;
    assign bus.write_data_1    = wd1_q;
    assign bus.first_byte_only = fbo_q;
    assign bus.write_enable_2  = we2_q;
    assign bus.write_addr_2    = wa2_q;
    assign bus.write_data_2    = wd2_q;
    assign bus.pending_1       = p1;
    assign bus.pending_2       = p2;
    assign bus.pending_15      = p15;

    always_comb begin
        head_e    = mem_q[head_q];
        push      = bus.in_valid && bus.in_ready;
        can_issue = count_q != '0 && !bus.wb_hold;
        // The register file drops port 2 on an address clash, so such entries take two cycles.
        same_addr = head_e.dual && head_e.a2 == head_e.a1;
        pop       = can_issue && (state_q == SPLIT || !same_addr);
        state_d   = !can_issue ? state_q : (state_q == ISSUE && same_addr) ? SPLIT : ISSUE;
        we1_d     = can_issue;
        wa1_d     = !can_issue ? '0 : state_q == SPLIT ? head_e.a2 : head_e.a1;
        wd1_d     = !can_issue ? '0 : state_q == SPLIT ? head_e.d2 : head_e.d1;
        fbo_d     = can_issue && state_q == ISSUE && head_e.bo;
        we2_d     = can_issue && state_q == ISSUE && head_e.dual && !same_addr;
        wa2_d     = we2_d ? head_e.a2 : '0;
        wd2_d     = we2_d ? head_e.d2 : '0;
        mem_d     = mem_q;
        if (push)
            mem_d[tail_q] = '{a1: bus.in_addr_1, d1: bus.in_data_1, bo: bus.in_byte_only,
                              dual: bus.in_dual, a2: bus.in_addr_2, d2: bus.in_data_2};
        tail_d    = tail_q + PW'(push);
        head_d    = head_q + PW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        p1  = (we1_q && wa1_q == bus.read_addr_1) || (we2_q && wa2_q == bus.read_addr_1);
        p2  = (we1_q && wa1_q == bus.read_addr_2) || (we2_q && wa2_q == bus.read_addr_2);
        p15 = (we1_q && wa1_q == ADDR_WIDTH'(15)) || (we2_q && wa2_q == ADDR_WIDTH'(15));
        for (int i = 0; i < DEPTH; i++) begin
            // Slot i is live when its distance from head is below the occupancy.
            vld = {1'b0, PW'(i) - head_q} < count_q;
            p1  = p1 || (vld && hits(mem_q[i], bus.read_addr_1));
            p2  = p2 || (vld && hits(mem_q[i], bus.read_addr_2));
            p15 = p15 || (vld && hits(mem_q[i], ADDR_WIDTH'(15)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ISSUE;
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we1_q   <= 1'b0;
            wa1_q   <= '0;
            wd1_q   <= '0;
            fbo_q   <= 1'b0;
            we2_q   <= 1'b0;
            wa2_q   <= '0;
            wd2_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we1_q   <= we1_d;
            wa1_q   <= wa1_d;
            wd1_q   <= wd1_d;
            fbo_q   <= fbo_d;
            we2_q   <= we2_d;
            wa2_q   <= wa2_d;
            wd2_q   <= wd2_d;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed self-checking bench for writeback_queue.
module tb_writeback_queue;
    logic clk, rst;
    int   cmp, bad;

    writeback_queue_if #(.DEPTH(4), .DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();
    writeback_queue #(.DEPTH(4), .DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        bus.read_addr_1 = 0;
        bus.read_addr_2 = 15;
        #1;
        cmp++;
        if (bus.write_enable_1 !== 0 || bus.write_enable_2 !== 0 || bus.write_addr_1 !== 0 || bus.write_data_1 !== 0
            || bus.first_byte_only !== 0 || bus.write_addr_2 !== 0 || bus.write_data_2 !== 0) begin
            bad++; $display("FAIL reset_outputs got we1=%b we2=%b wa1=%0d wd1=%h fbo=%b wa2=%0d wd2=%h required all 0",
                bus.write_enable_1, bus.write_enable_2, bus.write_addr_1, bus.write_data_1, bus.first_byte_only,
                bus.write_addr_2, bus.write_data_2);
        end
        cmp++;
        if (bus.in_ready !== 1 || bus.count !== 0) begin
            bad++; $display("FAIL reset_ready_count got ready=%b count=%0d required 1/0", bus.in_ready, bus.count);
        end
        cmp++;
        if (bus.pending_1 !== 0 || bus.pending_2 !== 0 || bus.pending_15 !== 0) begin
            bad++; $display("FAIL reset_pending got %b%b%b required 000", bus.pending_1, bus.pending_2, bus.pending_15);
        end
        step();
        rst = 0;
    endtask

    task automatic test_single();
        bus.in_valid = 1; bus.in_addr_1 = 3; bus.in_data_1 = 16'hABCD; bus.in_byte_only = 0; bus.in_dual = 0;
        bus.read_addr_1 = 3;
        step();
        bus.in_valid = 0;
        cmp++;
        if (bus.write_enable_1 !== 0 || bus.count !== 1 || bus.pending_1 !== 1) begin
            bad++; $display("FAIL single_pushed got we1=%b count=%0d pend=%b required 0/1/1",
                bus.write_enable_1, bus.count, bus.pending_1);
        end
        step();
        cmp++;
        if (bus.write_enable_1 !== 1 || bus.write_addr_1 !== 3 || bus.write_data_1 !== 16'hABCD
            || bus.write_enable_2 !== 0 || bus.first_byte_only !== 0 || bus.count !== 0) begin
            bad++; $display("FAIL single_issue got we1=%b wa1=%0d wd1=%h fbo=%b we2=%b count=%0d required 1/3/abcd/0/0/0",
                bus.write_enable_1, bus.write_addr_1, bus.write_data_1, bus.first_byte_only, bus.write_enable_2, bus.count);
        end
        step();
        cmp++;
        if (bus.write_enable_1 !== 0 || bus.count !== 0 || bus.pending_1 !== 0) begin
            bad++; $display("FAIL single_after got we1=%b count=%0d pend=%b required 0/0/0",
                bus.write_enable_1, bus.count, bus.pending_1);
        end
    endtask

    task automatic test_byte_dual();
        bus.in_valid = 1; bus.in_addr_1 = 5; bus.in_data_1 = 16'h1234; bus.in_byte_only = 1;
        bus.in_dual = 1; bus.in_addr_2 = 6; bus.in_data_2 = 16'h5678;
        step();
        bus.in_valid = 0;
        step();
        cmp++;
        if (bus.write_enable_1 !== 1 || bus.write_addr_1 !== 5 || bus.write_data_1 !== 16'h1234 || bus.first_byte_only !== 1
            || bus.write_enable_2 !== 1 || bus.write_addr_2 !== 6 || bus.write_data_2 !== 16'h5678) begin
            bad++; $display("FAIL dual_issue got we1=%b wa1=%0d wd1=%h fbo=%b we2=%b wa2=%0d wd2=%h required 1/5/1234/1/1/6/5678",
                bus.write_enable_1, bus.write_addr_1, bus.write_data_1, bus.first_byte_only,
                bus.write_enable_2, bus.write_addr_2, bus.write_data_2);
        end
        step();
        cmp++;
        if (bus.write_enable_1 !== 0 || bus.write_enable_2 !== 0 || bus.count !== 0) begin
            bad++; $display("FAIL dual_after got we1=%b we2=%b count=%0d required 0/0/0",
                bus.write_enable_1, bus.write_enable_2, bus.count);
        end
    endtask

    task automatic test_split();
        bus.in_valid = 1; bus.in_addr_1 = 7; bus.in_data_1 = 16'h1111; bus.in_byte_only = 0;
        bus.in_dual = 1; bus.in_addr_2 = 7; bus.in_data_2 = 16'h2222; bus.read_addr_2 = 7;
        step();
        bus.in_valid = 0;
        step();
        cmp++;
        if (bus.write_enable_1 !== 1 || bus.write_addr_1 !== 7 || bus.write_data_1 !== 16'h1111
            || bus.write_enable_2 !== 0 || bus.count !== 1 || bus.pending_2 !== 1) begin
            bad++; $display("FAIL split_a got we1=%b wa1=%0d wd1=%h we2=%b count=%0d pend=%b required 1/7/1111/0/1/1",
                bus.write_enable_1, bus.write_addr_1, bus.write_data_1, bus.write_enable_2, bus.count, bus.pending_2);
        end
        step();
        cmp++;
        if (bus.write_enable_1 !== 1 || bus.write_addr_1 !== 7 || bus.write_data_1 !== 16'h2222 || bus.first_byte_only !== 0
            || bus.write_enable_2 !== 0 || bus.count !== 0 || bus.pending_2 !== 1) begin
            bad++; $display("FAIL split_b got we1=%b wa1=%0d wd1=%h fbo=%b we2=%b count=%0d pend=%b required 1/7/2222/0/0/0/1",
                bus.write_enable_1, bus.write_addr_1, bus.write_data_1, bus.first_byte_only, bus.write_enable_2,
                bus.count, bus.pending_2);
        end
        step();
        cmp++;
        if (bus.write_enable_1 !== 0 || bus.pending_2 !== 0) begin
            bad++; $display("FAIL split_after got we1=%b pend=%b required 0/0", bus.write_enable_1, bus.pending_2);
        end
    endtask

    task automatic test_full();
        bus.wb_hold = 1; bus.in_dual = 0; bus.in_byte_only = 0; bus.in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_addr_1 = 4'(i); bus.in_data_1 = 16'h0100 + 16'(i);
            step();
        end
        cmp++;
        if (bus.count !== 4 || bus.in_ready !== 0 || bus.write_enable_1 !== 0) begin
            bad++; $display("FAIL full_state got count=%0d ready=%b we1=%b required 4/0/0",
                bus.count, bus.in_ready, bus.write_enable_1);
        end
        bus.in_addr_1 = 9; bus.in_data_1 = 16'h0999;
        step();
        cmp++;
        if (bus.count !== 4) begin
            bad++; $display("FAIL full_no_push got count=%0d required 4", bus.count);
        end
        bus.in_valid = 0; bus.wb_hold = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            cmp++;
            if (bus.write_enable_1 !== 1 || bus.write_addr_1 !== 4'(i) || bus.write_data_1 !== 16'h0100 + 16'(i)
                || bus.count !== 5'(4 - i) || bus.in_ready !== 1) begin
                bad++; $display("FAIL full_drain_%0d got we1=%b wa1=%0d wd1=%h count=%0d ready=%b required 1/%0d/%h/%0d/1",
                    i, bus.write_enable_1, bus.write_addr_1, bus.write_data_1, bus.count, bus.in_ready,
                    i, 16'h0100 + 16'(i), 4 - i);
            end
        end
        step();
        cmp++;
        if (bus.write_enable_1 !== 0 || bus.count !== 0) begin
            bad++; $display("FAIL full_after got we1=%b count=%0d required 0/0", bus.write_enable_1, bus.count);
        end
    endtask

    task automatic test_hazard_reset();
        bus.wb_hold = 1; bus.in_valid = 1; bus.in_dual = 0;
        bus.in_addr_1 = 15; bus.in_data_1 = 16'hF0F0;
        step();
        bus.in_addr_1 = 2; bus.in_data_1 = 16'h2222;
        step();
        bus.in_addr_1 = 3; bus.in_data_1 = 16'h3333; bus.in_dual = 1; bus.in_addr_2 = 11; bus.in_data_2 = 16'hBBBB;
        step();
        bus.in_valid = 0; bus.in_dual = 0; bus.read_addr_1 = 2; bus.read_addr_2 = 11;
        #1;
        cmp++;
        if (bus.count !== 3 || bus.pending_15 !== 1 || bus.pending_1 !== 1 || bus.pending_2 !== 1 || bus.write_enable_1 !== 0) begin
            bad++; $display("FAIL hazard_queued got count=%0d p15=%b p1=%b p2=%b we1=%b required 3/1/1/1/0",
                bus.count, bus.pending_15, bus.pending_1, bus.pending_2, bus.write_enable_1);
        end
        bus.read_addr_2 = 8;
        #1;
        cmp++;
        if (bus.pending_2 !== 0) begin
            bad++; $display("FAIL hazard_miss got %b required 0", bus.pending_2);
        end
        bus.wb_hold = 0;
        step();
        bus.wb_hold = 1;
        cmp++;
        if (bus.write_enable_1 !== 1 || bus.write_addr_1 !== 15 || bus.count !== 2 || bus.pending_15 !== 1) begin
            bad++; $display("FAIL hazard_inflight got we1=%b wa1=%0d count=%0d p15=%b required 1/15/2/1",
                bus.write_enable_1, bus.write_addr_1, bus.count, bus.pending_15);
        end
        #2;
        rst = 1;
        #1;
        cmp++;
        if (bus.count !== 0 || bus.write_enable_1 !== 0 || bus.write_enable_2 !== 0 || bus.pending_15 !== 0
            || bus.pending_1 !== 0 || bus.in_ready !== 1) begin
            bad++; $display("FAIL reset_midop got count=%0d we1=%b we2=%b p15=%b p1=%b ready=%b required 0/0/0/0/0/1",
                bus.count, bus.write_enable_1, bus.write_enable_2, bus.pending_15, bus.pending_1, bus.in_ready);
        end
        step();
        rst = 0; bus.wb_hold = 0;
    endtask

    initial begin
        cmp = 0; bad = 0;
        bus.in_valid = 0; bus.in_addr_1 = 0; bus.in_data_1 = 0; bus.in_byte_only = 0; bus.in_dual = 0;
        bus.in_addr_2 = 0; bus.in_data_2 = 0; bus.wb_hold = 0; bus.read_addr_1 = 0; bus.read_addr_2 = 0;
        test_reset();
        test_single();
        test_byte_dual();
        test_split();
        test_full();
        test_hazard_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
